// File: rtl/freq_synth_pkg.sv
// Shared definitions for the frequency synthesizer: controller state
// encoding and the Nyquist limit on the tuning word.
package freq_synth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  // Largest legal tuning word: half a turn of the phase circle.
  function automatic logic [63:0] nyq_limit(input int unsigned acc_w);
    return 64'd1 << (acc_w - 1);
  endfunction

endpackage

// File: rtl/freq_synth_acc.sv
// Phase accumulator for freq_synth: wraps modulo 2^ACC_W, reports the
// carry-out of the next add and registers the phase MSB as the clock output.
module freq_synth_acc #(
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             add_en,
  input  logic [ACC_W-1:0] step,
  output logic             carry,
  output logic             acc_msb,
  output logic             msb_p1
);

  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W:0]   sum;

  assign sum     = {1'b0, acc_p0} + {1'b0, step};
  assign carry   = sum[ACC_W];
  assign acc_msb = acc_p0[ACC_W-1];

  // Stage 0: phase register, cleared on reset or controller request
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      acc_p0 <= '0;
    end else if (add_en) begin
      acc_p0 <= sum[ACC_W-1:0];
    end
  end

  // Stage 1: output clock is the phase MSB delayed by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      msb_p1 <= 1'b0;
    end else begin
      msb_p1 <= acc_p0[ACC_W-1];
    end
  end

endmodule

// File: rtl/freq_synth.sv
// Phase-accumulator test-clock synthesizer with glitch-free retuning.
// New tuning words take effect only at a phase wrap, and disabling lets the
// current high phase finish, so clk_out never emits a runt pulse.
// Optional macro FREQ_SYNTH_EDGE_CNT_EN builds the rising-edge counter;
// without it edge_cnt is tied to zero.
module freq_synth
  import freq_synth_pkg::*;
#(
  parameter int ACC_W    = 32,
  parameter int SYS_FREQ = 50_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             en,
  input  logic [ACC_W-1:0] fw_data,
  input  logic             fw_valid,
  output logic             fw_ready,
  output logic             fw_err,
  output logic             clk_out,
  output logic [31:0]      edge_cnt
);

  if (ACC_W < 16 || ACC_W > 48 || SYS_FREQ <= 0) begin : g_param_chk
    $error("freq_synth: ACC_W must be 16..48 and SYS_FREQ positive");
  end

  localparam logic [ACC_W-1:0] NYQ = ACC_W'(nyq_limit(ACC_W));

  state_t           state_q, state_d;
  logic [ACC_W-1:0] act_q, act_d;
  logic [ACC_W-1:0] pnd_q, pnd_d;
  logic             err_q;
  logic             too_big, take;
  logic             add_en, acc_clr;
  logic             carry, acc_msb;

  freq_synth_acc #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk     (sys_clk),
    .rst     (sys_rst),
    .clr     (acc_clr),
    .add_en  (add_en),
    .step    (act_q),
    .carry   (carry),
    .acc_msb (acc_msb),
    .msb_p1  (clk_out)
  );

  // Handshake readiness: open in IDLE (when enabled) and RUN only
  always_comb begin
    fw_ready = 1'b0;
    if (!sys_rst) begin
      if (state_q == IDLE) begin
        fw_ready = en;
      end else if (state_q == RUN) begin
        fw_ready = 1'b1;
      end
    end
  end

  assign too_big = fw_data > NYQ;
  assign take    = fw_valid && fw_ready && !too_big;

  // Controller next state, word registers and accumulator control
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    pnd_d   = pnd_q;
    add_en  = 1'b0;
    acc_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (take && fw_data != '0) begin
          act_d   = fw_data;
          state_d = RUN;
        end
      end
      RUN: begin
        add_en = 1'b1;
        if (!en) begin
          state_d = STOP;
        end else if (take) begin
          pnd_d   = fw_data;
          state_d = PEND;
        end
      end
      PEND: begin
        add_en = 1'b1;
        if (!en) begin
          pnd_d   = '0;
          state_d = STOP;
        end else if (carry) begin
          // A zero pending word is a stop request honoured at the wrap.
          pnd_d = '0;
          if (pnd_q == '0) begin
            act_d   = '0;
            acc_clr = 1'b1;
            state_d = IDLE;
          end else begin
            act_d   = pnd_q;
            state_d = RUN;
          end
        end
      end
      default: begin
        // STOP: keep running through a high phase, park once MSB is low.
        if (acc_msb) begin
          add_en = 1'b1;
        end else begin
          act_d   = '0;
          acc_clr = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end

  // Controller state and tuning-word registers
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      act_q   <= '0;
      pnd_q   <= '0;
    end else begin
      state_q <= state_d;
      act_q   <= act_d;
      pnd_q   <= pnd_d;
    end
  end

  // Reject flag: pulses the cycle after an above-Nyquist word is offered
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= fw_valid && fw_ready && too_big;
    end
  end

  assign fw_err = err_q;

`ifdef FREQ_SYNTH_EDGE_CNT_EN
  logic rise, cnt_clr;

  // A rise happens when the phase MSB is about to be registered high.
  assign rise    = acc_msb && !clk_out;
  // Entering RUN means a new word has just been applied.
  assign cnt_clr = (state_d == RUN) && (state_q != RUN);

  // Saturating count of clk_out rising edges since the last applied word
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      edge_cnt <= '0;
    end else if (cnt_clr) begin
      edge_cnt <= {31'd0, rise};
    end else if (rise && edge_cnt != '1) begin
      edge_cnt <= edge_cnt + 32'd1;
    end
  end
`else
  assign edge_cnt = '0;
`endif

endmodule

// File: tb/tb_freq_synth.sv
// Bench for freq_synth (ACC_W = 32): directed scenarios plus randomized
// traffic, all compared against a phase-circle reference model.
module tb_freq_synth;

  localparam int ACC_W = 32;
  localparam longint unsigned MOD  = 64'd1 << 32;
  localparam longint unsigned HALF = 64'd1 << 31;
`ifdef FREQ_SYNTH_EDGE_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic             sys_clk = 1'b0;
  logic             sys_rst = 1'b1;
  logic             en = 1'b0;
  logic [ACC_W-1:0] fw_data = '0;
  logic             fw_valid = 1'b0;
  logic             fw_ready, fw_err, clk_out;
  logic [31:0]      edge_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  freq_synth #(
    .ACC_W    (ACC_W),
    .SYS_FREQ (50_000_000)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .en       (en),
    .fw_data  (fw_data),
    .fw_valid (fw_valid),
    .fw_ready (fw_ready),
    .fw_err   (fw_err),
    .clk_out  (clk_out),
    .edge_cnt (edge_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input longint unsigned got, input longint unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // Mode: 0 idle, 1 running, 2 retune waiting for wrap, 3 winding down.
  int              m_mode = 0;
  longint unsigned m_phase = 0, m_word = 0, m_next = 0, m_cnt = 0;
  bit              m_out = 0, m_err = 0;

  function automatic bit m_ready();
    if (sys_rst) return 1'b0;
    return (m_mode == 0 && en) || (m_mode == 1);
  endfunction

  always @(posedge sys_clk) begin
    bit rdy, take, rise, restart;
    longint unsigned d, sum;
    d    = fw_data;
    rdy  = m_ready();
    take = fw_valid && rdy && (d <= HALF);
    if (sys_rst) begin
      m_mode = 0; m_phase = 0; m_word = 0; m_next = 0;
      m_out = 0; m_err = 0; m_cnt = 0;
    end else begin
      m_err   = fw_valid && rdy && (d > HALF);
      // Output shows whether the phase sat in the upper half last cycle.
      rise    = (m_phase >= HALF) && !m_out;
      m_out   = (m_phase >= HALF);
      restart = 0;
      sum     = m_phase + m_word;
      case (m_mode)
        0: if (take && d != 0) begin m_word = d; m_mode = 1; restart = 1; end
        1: begin
          m_phase = sum % MOD;
          if (!en) m_mode = 3;
          else if (take) begin m_next = d; m_mode = 2; end
        end
        2: begin
          m_phase = sum % MOD;
          if (!en) m_mode = 3;
          else if (sum >= MOD) begin
            if (m_next == 0) begin m_mode = 0; m_phase = 0; end
            else begin m_word = m_next; m_mode = 1; restart = 1; end
          end
        end
        default: begin
          if (m_phase < HALF) begin m_phase = 0; m_mode = 0; end
          else m_phase = sum % MOD;
        end
      endcase
      if (restart) m_cnt = rise ? 1 : 0;
      else if (rise && m_cnt < 64'hFFFF_FFFF) m_cnt++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input bit v, input logic [31:0] d);
    fw_valid = v;
    fw_data  = d;
    #1;
    chk("fw_ready", fw_ready, m_ready());
    @(posedge sys_clk);
    cyc++;
    @(negedge sys_clk);
    chk("clk_out", clk_out, m_out);
    chk("fw_err", fw_err, m_err);
    chk("edge_cnt", edge_cnt, CNT_ON ? m_cnt : 0);
  endtask

  task automatic do_reset();
    sys_rst = 1'b1;
    tick(0, 0);
    tick(0, 0);
    sys_rst = 1'b0;
  endtask

  // Ticks until clk_out rises (bounded).
  task automatic wait_rise(output int n);
    n = 0;
    while (clk_out == 1'b1 && n < 10000) begin tick(0, 0); n++; end
    while (clk_out == 1'b0 && n < 10000) begin tick(0, 0); n++; end
  endtask

  // Number of consecutive samples at level lvl, starting with the current one.
  task automatic run_len(input bit lvl, output int n);
    n = 0;
    while (clk_out == lvl && n < 100) begin n++; tick(0, 0); end
  endtask

  function automatic logic [31:0] rand_word();
    case ($urandom_range(0, 5))
      0:       return 32'h1 << $urandom_range(24, 31);
      1:       return $urandom_range(32'h0100_0000, 32'h8000_0000);
      2:       return 32'h0;
      3:       return 32'h8000_0000 + $urandom_range(1, 1000);
      4:       return $urandom;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h, l, rises, highs;
    bit prev;

    // Reset state
    do_reset();
    chk("rst_clk_out", clk_out, 0);
    chk("rst_fw_err", fw_err, 0);
    chk("rst_edge_cnt", edge_cnt, 0);

    // Word 2^28: first rise 9 cycles after accept, then 8 high / 8 low
    en = 1'b1;
    tick(1, 32'h1000_0000);
    wait_rise(n);
    chk("first_rise", n, 9);
    run_len(1'b1, h);
    chk("hi_2p28", h, 8);
    run_len(1'b0, l);
    chk("lo_2p28", l, 8);

    // Retune to 2^27 mid high phase: pulse completes, then period 32
    tick(0, 0);
    tick(0, 0);
    tick(1, 32'h0800_0000);
    #1;
    chk("ready_pend", fw_ready, 0);
    run_len(1'b1, h);
    chk("hi_rest", h, 5);
    chk("cnt_restart", edge_cnt, 0);
    run_len(1'b0, l);
    chk("lo_2p27", l, 16);
    chk("cnt_after_retune", edge_cnt, CNT_ON ? 1 : 0);
    run_len(1'b1, h);
    chk("hi_2p27", h, 16);

    // Enable dropped during a high phase: full high, then quiet
    do_reset();
    en = 1'b1;
    tick(1, 32'h1000_0000);
    wait_rise(n);
    tick(0, 0);
    tick(0, 0);
    en = 1'b0;
    tick(0, 0);
    run_len(1'b1, h);
    chk("stop_hi", h, 5);
    highs = 0;
    for (int i = 0; i < 30; i++) begin
      if (clk_out) highs++;
      tick(0, 0);
    end
    chk("stop_quiet", highs, 0);
    chk("stop_ready", fw_ready, 0);

    // Word 2^31 toggles every cycle; 2^31+1 rejected with a single err pulse
    en = 1'b1;
    tick(1, 32'h8000_0000);
    wait_rise(n);
    for (int i = 0; i < 6; i++) begin
      prev = clk_out;
      tick(0, 0);
      chk("toggle", clk_out, !prev);
    end
    prev = clk_out;
    tick(1, 32'h8000_0001);
    chk("err_pulse", fw_err, 1);
    chk("toggle_err", clk_out, !prev);
    prev = clk_out;
    tick(0, 0);
    chk("err_once", fw_err, 0);
    chk("toggle_after", clk_out, !prev);

    // Ten periods at 2^28
    do_reset();
    en = 1'b1;
    tick(1, 32'h1000_0000);
    rises = 0;
    n = 0;
    while (rises < 10 && n < 400) begin
      prev = clk_out;
      tick(0, 0);
      if (!prev && clk_out) rises++;
      n++;
    end
    chk("rises10", rises, 10);
    chk("edge10", edge_cnt, CNT_ON ? 10 : 0);

    // Reset mid-run
    tick(0, 0);
    sys_rst = 1'b1;
    #1;
    chk("rst_ready_low", fw_ready, 0);
    tick(0, 0);
    chk("midrst_clk_out", clk_out, 0);
    chk("midrst_edge_cnt", edge_cnt, 0);
    chk("midrst_fw_err", fw_err, 0);
    sys_rst = 1'b0;
    #1;
    chk("post_rst_ready", fw_ready, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 99) == 0) en = ~en;
      sys_rst = ($urandom_range(0, 799) == 0);
      tick($urandom_range(0, 9) == 0, rand_word());
    end
    sys_rst = 1'b0;
    tick(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
